shift_register_multi: RTL and testbench
=======================================

Name: shift_register_multi

Overview:
Parametrised successor of the fixed 1028-bit radix-4 shift register used by the Montgomery adder datapath. It holds a WIDTH-bit operand and, on request, performs a programmed number of SHIFT-bit steps, left or right, one step per clock. It reports progress with busy and a single-cycle shift_done pulse. out_digit exposes the low SHIFT bits as the current radix digit for the multiplier control FSM.

Parameters:
WIDTH, 1028, operand width in bits
SHIFT, 2, bits shifted per step (radix 2^SHIFT); legal range 1 <= SHIFT < WIDTH
CNT_W, 10, width of the step-count input

Ports:
clk  input  1  clock, rising edge
restn  input  1  asynchronous active-low reset
in_number  input  WIDTH  operand to load
load  input  1  load in_number (honoured in IDLE only)
start  input  1  begin a shift sequence (honoured in IDLE only)
shift_count  input  CNT_W  number of steps N, sampled with start
dir  input  1  0 = logical right, 1 = logical left; sampled with start
out_shift  output  WIDTH  registered operand value
out_digit  output  SHIFT  combinational, out_shift[SHIFT-1:0]
busy  output  1  registered; high while state != IDLE
shift_done  output  1  registered; one-cycle pulse at end of sequence

Behaviour:
- Reset is asynchronous (restn low), independent of clk. While restn is low: out_shift=0, state=IDLE, step counter=0, latched dir=0, busy=0, shift_done=0. Reset mid-sequence aborts it with no shift_done pulse.
- FSM states:
  - IDLE: accepts load and start.
  - SHIFT: one step per clock.
  - DONE: one cycle, shift_done=1.
- IDLE, load=1: out_shift <= in_number at that edge. If start is also high, load wins and start is dropped.
- IDLE, start=1, load=0, edge E0: latch N and dir.
  - N>0: go to SHIFT with counter=N.
  - N=0: go to DONE directly; out_shift unchanged.
- SHIFT, edges E1..EN: each edge sets out_shift <= out_shift >> SHIFT (dir=0) or << SHIFT (dir=1) and decrements the counter.
  - Vacated bits are zero-filled. Bits shifted out are discarded.
  - At EN, the counter reaches 0 and the state moves to DONE.
- DONE: shift_done=1 for exactly the cycle following EN (following E0 when N=0). The next edge returns to IDLE with shift_done=0 and busy=0.
- busy is high from the edge after E0 until the edge that returns to IDLE, inclusive of the DONE cycle.
- Latency from start to shift_done high is N+1 edges.
- load, start, shift_count and dir are ignored while busy. in_number changes never affect a running sequence.
- A new start may be accepted in the first IDLE cycle after DONE (back-to-back sequences are separated by exactly one IDLE cycle).
- Worst case N = 2^CNT_W - 1. Shifting past WIDTH yields 0 (no wrap).
- No X propagation: all state is reset. out_digit tracks out_shift combinationally.

Test Plan:
(All with WIDTH=16, SHIFT=2, CNT_W=4 unless stated.)
1. Load 0xBEEF, then pull restn low between clock edges -> out_shift=0x0000, busy=0, shift_done=0 immediately, without waiting for a clk edge.
2. Load 0xF00D; start N=3, dir=0 -> out_shift steps 0x3C03, 0x0F00, 0x03C0. shift_done is high for one cycle after the 3rd shift edge. busy is high for 4 cycles. out_digit ends at 2'b00.
3. Load 0x8001; start N=2, dir=1 -> out_shift 0x0004, then 0x0010. shift_done pulses once. out_digit reads 2'b01, 2'b00, 2'b00 across the sequence.
4. Load 0x1234; start N=0 -> shift_done high in the cycle after start, busy high that cycle only, out_shift stays 0x1234.
5. Load 0xAAAA; start N=2, dir=0. While busy, assert load with 0xFFFF and start N=5 -> both ignored, final out_shift=0x0AAA. Then in IDLE assert load(0x5555) and start together -> out_shift=0x5555, no sequence begins.
6. Start N=15 on 0xFFFF and pull restn low after 4 shifts -> out_shift=0, no shift_done pulse. After release, load 0x00F0 and start N=1, dir=0 -> 0x003C, normal single shift_done pulse.

Source files
------------

// File: rtl/shift_register_multi.sv
// Multi-step logical shift register: holds a WIDTH-bit operand and shifts it by SHIFT bits
// per clock for a programmed number of steps, reporting busy and a one-cycle shift_done.
module shift_register_multi #(
  parameter int unsigned WIDTH = 1028,
  parameter int unsigned SHIFT = 2,
  parameter int unsigned CNT_W = 10
) (
  input  logic             clk,
  input  logic             restn,
  input  logic [WIDTH-1:0] in_number,
  input  logic             load,
  input  logic             start,
  input  logic [CNT_W-1:0] shift_count,
  input  logic             dir,
  output logic [WIDTH-1:0] out_shift,
  output logic [SHIFT-1:0] out_digit,
  output logic             busy,
  output logic             shift_done
);

  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StShift = 2'd1,
    StDone  = 2'd2
  } state_e;

  state_e             state_q, state_d;
  logic [WIDTH-1:0]   data_q, data_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               dir_q, dir_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;

  always_comb begin
    state_d = state_q;
    data_d  = data_q;
    cnt_d   = cnt_q;
    dir_d   = dir_q;

    unique case (state_q)
      StIdle: begin
        // load has priority; a simultaneous start is dropped
        if (load) begin
          data_d = in_number;
        end else if (start) begin
          cnt_d   = shift_count;
          dir_d   = dir;
          state_d = (shift_count == '0) ? StDone : StShift;
        end
      end
      StShift: begin
        data_d = dir_q ? (data_q << SHIFT) : (data_q >> SHIFT);
        cnt_d  = cnt_q - CNT_W'(1);
        if (cnt_q == CNT_W'(1)) begin
          state_d = StDone;
        end
      end
      StDone: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase

    // Status flags are registered from the next state so they align with it.
    busy_d = (state_d != StIdle);
    done_d = (state_d == StDone);
  end

  always_ff @(posedge clk or negedge restn) begin
    if (!restn) begin
      state_q <= StIdle;
      data_q  <= '0;
      cnt_q   <= '0;
      dir_q   <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      data_q  <= data_d;
      cnt_q   <= cnt_d;
      dir_q   <= dir_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign out_shift  = data_q;
  assign out_digit  = data_q[SHIFT-1:0];
  assign busy       = busy_q;
  assign shift_done = done_q;

endmodule

// File: tb/tb_shift_register_multi.sv
// Directed bench for shift_register_multi at WIDTH=16, SHIFT=2, CNT_W=4: a per-cycle vector
// table plus hand sequences for asynchronous reset and long shifts.
module tb_shift_register_multi;

  localparam int unsigned WIDTH = 16;
  localparam int unsigned SHIFT = 2;
  localparam int unsigned CNT_W = 4;

  logic             clk;
  logic             restn;
  logic [WIDTH-1:0] in_number;
  logic             load;
  logic             start;
  logic [CNT_W-1:0] shift_count;
  logic             dir;
  logic [WIDTH-1:0] out_shift;
  logic [SHIFT-1:0] out_digit;
  logic             busy;
  logic             shift_done;

  int checks = 0;
  int errors = 0;

  shift_register_multi #(
    .WIDTH(WIDTH),
    .SHIFT(SHIFT),
    .CNT_W(CNT_W)
  ) dut (
    .clk        (clk),
    .restn      (restn),
    .in_number  (in_number),
    .load       (load),
    .start      (start),
    .shift_count(shift_count),
    .dir        (dir),
    .out_shift  (out_shift),
    .out_digit  (out_digit),
    .busy       (busy),
    .shift_done (shift_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic             load;
    logic             start;
    logic [WIDTH-1:0] in_number;
    logic [CNT_W-1:0] count;
    logic             dir;
    logic [WIDTH-1:0] exp_out;
    logic [SHIFT-1:0] exp_digit;
    logic             exp_busy;
    logic             exp_done;
  } vec_t;

  vec_t vecs[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic chk_all(input string tag, input logic [WIDTH-1:0] eo, input logic [SHIFT-1:0] ed,
                         input logic eb, input logic edn);
    chk({tag, ".out_shift"}, 32'(out_shift), 32'(eo));
    chk({tag, ".out_digit"}, 32'(out_digit), 32'(ed));
    chk({tag, ".busy"}, 32'(busy), 32'(eb));
    chk({tag, ".shift_done"}, 32'(shift_done), 32'(edn));
  endtask

  task automatic drive(input logic l, input logic s, input logic [WIDTH-1:0] n,
                       input logic [CNT_W-1:0] c, input logic d);
    load = l; start = s; in_number = n; shift_count = c; dir = d;
  endtask

  // Apply inputs for one edge, then sample just after it.
  task automatic step(input logic l, input logic s, input logic [WIDTH-1:0] n,
                      input logic [CNT_W-1:0] c, input logic d);
    drive(l, s, n, c, d);
    @(posedge clk);
    #1;
  endtask

  function automatic vec_t mk(input logic l, input logic s, input logic [WIDTH-1:0] n,
                              input logic [CNT_W-1:0] c, input logic d, input logic [WIDTH-1:0] eo,
                              input logic [SHIFT-1:0] ed, input logic eb, input logic edn);
    vec_t v;
    v.load = l; v.start = s; v.in_number = n; v.count = c; v.dir = d;
    v.exp_out = eo; v.exp_digit = ed; v.exp_busy = eb; v.exp_done = edn;
    return v;
  endfunction

  int cyc;
  logic seen_done;

  initial begin
    restn = 1'b0;
    drive(1'b0, 1'b0, '0, '0, 1'b0);

    //            ld st in       N  dir  out      dig   busy done
    // Right shift of 0xF00D by 3 steps
    vecs.push_back(mk(1, 0, 16'hF00D, 0, 0, 16'hF00D, 2'b01, 0, 0));
    vecs.push_back(mk(0, 1, 16'h0000, 3, 0, 16'hF00D, 2'b01, 1, 0));
    vecs.push_back(mk(0, 0, 16'h0000, 0, 0, 16'h3C03, 2'b11, 1, 0));
    vecs.push_back(mk(0, 0, 16'h0000, 0, 0, 16'h0F00, 2'b00, 1, 0));
    vecs.push_back(mk(0, 0, 16'h0000, 0, 0, 16'h03C0, 2'b00, 1, 1));
    vecs.push_back(mk(0, 0, 16'h0000, 0, 0, 16'h03C0, 2'b00, 0, 0));
    // Left shift of 0x8001 by 2 steps, MSB drops off
    vecs.push_back(mk(1, 0, 16'h8001, 0, 0, 16'h8001, 2'b01, 0, 0));
    vecs.push_back(mk(0, 1, 16'h0000, 2, 1, 16'h8001, 2'b01, 1, 0));
    vecs.push_back(mk(0, 0, 16'h0000, 0, 0, 16'h0004, 2'b00, 1, 0));
    vecs.push_back(mk(0, 0, 16'h0000, 0, 0, 16'h0010, 2'b00, 1, 1));
    vecs.push_back(mk(0, 0, 16'h0000, 0, 0, 16'h0010, 2'b00, 0, 0));
    // N=0 goes straight to DONE; a start during DONE is ignored
    vecs.push_back(mk(1, 0, 16'h1234, 0, 0, 16'h1234, 2'b00, 0, 0));
    vecs.push_back(mk(0, 1, 16'h0000, 0, 0, 16'h1234, 2'b00, 1, 1));
    vecs.push_back(mk(0, 1, 16'h0000, 0, 0, 16'h1234, 2'b00, 0, 0));
    vecs.push_back(mk(0, 0, 16'h0000, 0, 0, 16'h1234, 2'b00, 0, 0));
    // load/start while busy ignored; load beats start in IDLE
    vecs.push_back(mk(1, 0, 16'hAAAA, 0, 0, 16'hAAAA, 2'b10, 0, 0));
    vecs.push_back(mk(0, 1, 16'h0000, 2, 0, 16'hAAAA, 2'b10, 1, 0));
    vecs.push_back(mk(1, 1, 16'hFFFF, 5, 1, 16'h2AAA, 2'b10, 1, 0));
    vecs.push_back(mk(1, 1, 16'hFFFF, 5, 1, 16'h0AAA, 2'b10, 1, 1));
    vecs.push_back(mk(0, 0, 16'h0000, 0, 0, 16'h0AAA, 2'b10, 0, 0));
    vecs.push_back(mk(1, 1, 16'h5555, 3, 0, 16'h5555, 2'b01, 0, 0));
    vecs.push_back(mk(0, 0, 16'h0000, 0, 0, 16'h5555, 2'b01, 0, 0));
    // Back-to-back: second start accepted in the first IDLE cycle after DONE
    vecs.push_back(mk(0, 1, 16'h0000, 1, 1, 16'h5555, 2'b01, 1, 0));
    vecs.push_back(mk(0, 0, 16'h0000, 0, 0, 16'h5554, 2'b00, 1, 1));
    vecs.push_back(mk(0, 0, 16'h0000, 0, 0, 16'h5554, 2'b00, 0, 0));
    vecs.push_back(mk(0, 1, 16'h0000, 1, 0, 16'h5554, 2'b00, 1, 0));
    vecs.push_back(mk(0, 0, 16'h0000, 0, 0, 16'h1555, 2'b01, 1, 1));
    vecs.push_back(mk(0, 0, 16'h0000, 0, 0, 16'h1555, 2'b01, 0, 0));

    // Reset state
    #12;
    chk_all("reset", 16'h0000, 2'b00, 1'b0, 1'b0);
    restn = 1'b1;
    @(posedge clk);
    #1;

    // Asynchronous reset clears a loaded value without a clock edge
    step(1, 0, 16'hBEEF, 0, 0);
    chk_all("load_beef", 16'hBEEF, 2'b11, 1'b0, 1'b0);
    drive(0, 0, 16'h0000, 0, 0);
    #2;
    restn = 1'b0;
    #1;
    chk_all("async_rst", 16'h0000, 2'b00, 1'b0, 1'b0);
    #1;
    restn = 1'b1;
    @(posedge clk);
    #1;

    foreach (vecs[i]) begin
      step(vecs[i].load, vecs[i].start, vecs[i].in_number, vecs[i].count, vecs[i].dir);
      chk_all($sformatf("vec%0d", i), vecs[i].exp_out, vecs[i].exp_digit, vecs[i].exp_busy,
              vecs[i].exp_done);
    end

    // Worst-case N=15 left shift: shifting past WIDTH yields 0, done after N+1 edges
    step(1, 0, 16'hFFFF, 0, 0);
    step(0, 1, 16'h0000, 15, 1);
    cyc = 1;
    while (!shift_done && cyc < 40) begin
      step(0, 0, 16'h0000, 0, 0);
      cyc++;
    end
    chk("max_n.latency", 32'(cyc), 32'd16);
    chk_all("max_n.end", 16'h0000, 2'b00, 1'b1, 1'b1);
    step(0, 0, 16'h0000, 0, 0);
    chk_all("max_n.idle", 16'h0000, 2'b00, 1'b0, 1'b0);

    // Reset mid-sequence aborts without a shift_done pulse
    step(1, 0, 16'hFFFF, 0, 0);
    step(0, 1, 16'h0000, 15, 0);
    for (int k = 0; k < 4; k++) step(0, 0, 16'h0000, 0, 0);
    chk_all("abort.pre", 16'h00FF, 2'b11, 1'b1, 1'b0);
    #2;
    restn = 1'b0;
    #1;
    chk_all("abort.rst", 16'h0000, 2'b00, 1'b0, 1'b0);
    seen_done = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(posedge clk);
      #1;
      seen_done = seen_done | shift_done | busy;
    end
    chk("abort.quiet", 32'(seen_done), 32'd0);
    #2;
    restn = 1'b1;
    @(posedge clk);
    #1;
    chk_all("abort.post", 16'h0000, 2'b00, 1'b0, 1'b0);

    step(1, 0, 16'h00F0, 0, 0);
    step(0, 1, 16'h0000, 1, 0);
    chk_all("recover.e0", 16'h00F0, 2'b00, 1'b1, 1'b0);
    step(0, 0, 16'h0000, 0, 0);
    chk_all("recover.e1", 16'h003C, 2'b00, 1'b1, 1'b1);
    step(0, 0, 16'h0000, 0, 0);
    chk_all("recover.idle", 16'h003C, 2'b00, 1'b0, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
